// File: rtl/vram_fill_arbiter.sv
// Video RAM write-port arbiter: core VGA writes (strict priority, zero latency) versus a rectangle-fill engine.
// Optional build macro FILL_CLEAR_ON_RESET_EN: full-screen CLEAR_COLOR fill right after reset.
module vram_fill_arbiter #(
  parameter int unsigned COORD_WIDTH = 8,
  parameter int unsigned COLOR_WIDTH = 3,
  parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0,
  localparam int unsigned ADDR_WIDTH = 2 * COORD_WIDTH
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   iCpuWe,
  input  logic [ADDR_WIDTH-1:0]  iCpuAddr,
  input  logic [COLOR_WIDTH-1:0] iCpuColor,
  input  logic                   iFillStart,
  input  logic [COORD_WIDTH-1:0] iX0,
  input  logic [COORD_WIDTH-1:0] iY0,
  input  logic [COORD_WIDTH-1:0] iX1,
  input  logic [COORD_WIDTH-1:0] iY1,
  input  logic [COLOR_WIDTH-1:0] iFillColor,
  output logic                   oFillBusy,
  output logic                   oFillDone,
  output logic                   oWriteEnable,
  output logic [ADDR_WIDTH-1:0]  oWriteAddress,
  output logic [COLOR_WIDTH-1:0] oDataIn
);

  localparam logic [COORD_WIDTH-1:0] COORD_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fillState_t;

  fillState_t             state;
  logic [COORD_WIDTH-1:0] xMin, xMax, yMin, yMax;
  logic [COORD_WIDTH-1:0] x, y;
  logic [COLOR_WIDTH-1:0] fillColor;
  logic                   fillBusy;
  logic                   fillDone;
  logic                   fillWrite;

  // The fill engine only gets the port in cycles the core leaves free.
`ifdef FILL_CLEAR_ON_RESET_EN
  assign fillWrite = (state == FILL) && !iCpuWe && !Reset;
`else
  assign fillWrite = (state == FILL) && !iCpuWe;
`endif

  // Fill FSM and scan counters; row/last-pixel detection by equality so 255 never wraps.
  always_ff @(posedge Clock) begin
    if (Reset) begin
`ifdef FILL_CLEAR_ON_RESET_EN
      state     <= FILL;
      xMin      <= '0;
      xMax      <= COORD_MAX;
      yMin      <= '0;
      yMax      <= COORD_MAX;
      x         <= '0;
      y         <= '0;
      fillColor <= CLEAR_COLOR;
      fillBusy  <= 1'b1;
`else
      state     <= IDLE;
      xMin      <= '0;
      xMax      <= '0;
      yMin      <= '0;
      yMax      <= '0;
      x         <= '0;
      y         <= '0;
      fillColor <= '0;
      fillBusy  <= 1'b0;
`endif
      fillDone  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          fillDone <= 1'b0;
          if (iFillStart) begin
            xMin      <= (iX0 < iX1) ? iX0 : iX1;
            xMax      <= (iX0 < iX1) ? iX1 : iX0;
            yMin      <= (iY0 < iY1) ? iY0 : iY1;
            yMax      <= (iY0 < iY1) ? iY1 : iY0;
            x         <= (iX0 < iX1) ? iX0 : iX1;
            y         <= (iY0 < iY1) ? iY0 : iY1;
            fillColor <= iFillColor;
            fillBusy  <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          if (fillWrite) begin
            if (x == xMax) begin
              x <= xMin;
              if (y == yMax) begin
                state    <= DONE;
                fillBusy <= 1'b0;
                fillDone <= 1'b1;
              end else begin
                y <= y + COORD_WIDTH'(1);
              end
            end else begin
              x <= x + COORD_WIDTH'(1);
            end
          end
        end
        DONE: begin
          fillDone <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          fillBusy <= 1'b0;
          fillDone <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign oFillBusy = fillBusy;
  assign oFillDone = fillDone;

  // Write-port mux: core first, then fill pixel, else idle bus driven to zero.
  always_comb begin
    oWriteEnable  = 1'b0;
    oWriteAddress = '0;
    oDataIn       = '0;
    if (iCpuWe) begin
      oWriteEnable  = 1'b1;
      oWriteAddress = iCpuAddr;
      oDataIn       = iCpuColor;
    end else if (fillWrite) begin
      oWriteEnable  = 1'b1;
      oWriteAddress = {x, y};
      oDataIn       = fillColor;
    end
  end

endmodule
